apb_master_bridge: RTL and testbench
====================================

# apb_master_bridge

Parametrised APB4 requester that turns a simple valid/ready request port into compliant SETUP/ACCESS bus cycles and returns read data and error status on a one-cycle response strobe. It generalises our fixed 8-bit APB top to configurable address/data width. It adds wait-state support (`pready`), slave error reporting (`pslverr`), byte strobes (`pstrb`) and an optional access timeout. It sits between a core-side controller and the APB slaves of the peripheral subsystem.

## Interface
Parameters:
- `ADDR_W`, 8: address width.
- `DATA_W`, 32: data width; must be a multiple of 8.
- `TIMEOUT_CYC`, 16: maximum wait cycles in ACCESS; used only when `APB_TIMEOUT_EN` is defined; must be at least 1.

Ports (clock and reset first; one clock, reset asynchronous and active-low):
- `pclk` in 1: clock; all logic is rising-edge.
- `presetn` in 1: asynchronous active-low reset.
- `req_valid` in 1: a request is presented.
- `req_ready` out 1: the block can accept a request.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_W: target address.
- `req_wdata` in DATA_W: write data.
- `req_strb` in DATA_W/8: write byte enables.
- `rsp_valid` out 1: one-cycle pulse when a transfer completes.
- `rsp_rdata` out DATA_W: read data; 0 for writes and errors.
- `rsp_err` out 1: the transfer ended in error; qualified by `rsp_valid`.
- `paddr` out ADDR_W, `pwrite` out 1, `pwdata` out DATA_W, `pstrb` out DATA_W/8: APB request signals.
- `psel` out 1, `penable` out 1: APB phase controls.
- `prdata` in DATA_W, `pready` in 1, `pslverr` in 1: APB slave response signals.

## Operation
- The FSM has three states: IDLE, SETUP and ACCESS. All outputs are registered.
- Reset value of every output is 0. This includes `req_ready`, which rises on the first `pclk` edge after `presetn` is released.
- Acceptance: the block accepts a request when `req_valid` and `req_ready` are both 1 on a clock edge.
  - On acceptance it latches `paddr`, `pwrite`, `pwdata` and `pstrb`, sets `psel=1` and `req_ready=0`, and enters SETUP.
  - For reads, `pstrb` is driven to 0 and `pwdata` to 0.
- SETUP: the state lasts exactly one cycle. The block then sets `penable=1` and enters ACCESS.
- ACCESS: the block waits while `pready=0`. When it samples `pready=1`:
  - `psel`, `penable`, `pstrb` and `pwrite` go to 0, and the FSM returns to IDLE.
  - `req_ready` goes to 1 and `rsp_valid` goes to 1 for one cycle.
  - `rsp_err` takes the value of `pslverr`.
  - `rsp_rdata` takes `prdata` for a read with no error; otherwise it is 0.
- `paddr`, `pwrite`, `pwdata` and `pstrb` stay stable from SETUP through the last ACCESS cycle. The block never starts a new transfer without passing through IDLE.
- `req_valid` while `req_ready=0` is ignored. The requester must hold its request until accepted.
- Reset mid-transfer: all outputs clear immediately and asynchronously. No response is issued and the in-flight transfer is dropped.

## Timing
- Zero-wait transfer, with acceptance at edge 0:
  - SETUP (`psel=1`, `penable=0`) is visible after edge 0.
  - ACCESS (`penable=1`) is visible after edge 1.
  - `pready=1` is sampled at edge 2.
  - `rsp_valid` and `req_ready` are high after edge 2.
- Latency from acceptance to response is 3 edges plus N wait cycles.
- Back-to-back transfers: a request accepted on the `rsp_valid` cycle starts SETUP on the next edge. Throughput is therefore one transfer per 3 cycles with zero waits.
- `pslverr` and `prdata` are sampled only on the edge where `penable=1` and `pready=1`.

## Configuration
- `APB_TIMEOUT_EN` defined:
  - A counter clears on entry to ACCESS and increments on each ACCESS edge with `pready=0`.
  - On the edge where the count reaches `TIMEOUT_CYC` with `pready` still 0, the block aborts: it drops `psel`/`penable`, returns to IDLE and issues `rsp_valid=1`, `rsp_err=1`, `rsp_rdata=0`.
  - If `pready=1` arrives on that same edge, normal completion wins.
- `APB_TIMEOUT_EN` undefined: there is no counter, ACCESS waits indefinitely, and `TIMEOUT_CYC` is unused.

## Test plan
All scenarios use `ADDR_W=8`, `DATA_W=32`, `TIMEOUT_CYC=4`.
- Reset: `presetn=0` for 2 cycles, then released → all outputs 0 during reset; `req_ready=1` one edge after release.
- Zero-wait write: request write, addr 0x05, data 0xDEADBEEF, strb 0xF → `paddr=0x05`, `pwdata=0xDEADBEEF`, `pstrb=0xF` through SETUP/ACCESS; `rsp_valid` 3 edges after acceptance with `rsp_err=0`, `rsp_rdata=0`.
- Read with 2 waits: read addr 0x05; slave returns `prdata=0xA5A5A5A5` with `pready` held 0 for 2 ACCESS cycles → `pstrb=0`; `rsp_rdata=0xA5A5A5A5` 5 edges after acceptance.
- Slave error: read addr 0x10 with `pslverr=1` on completion → `rsp_err=1`, `rsp_rdata=0`.
- Back-to-back: two writes to 0x01 and 0x02, with `req_valid` held high → second SETUP immediately follows the first `rsp_valid` cycle; no cycle has `psel=0` between IDLE and SETUP other than the IDLE/response cycle.
- Timeout and mid-transfer reset:
  - With `APB_TIMEOUT_EN` and `pready` stuck at 0 → abort after 4 wait edges with `rsp_err=1`.
  - Without the macro, the bench instead asserts `presetn=0` during ACCESS → `psel`/`penable` fall immediately and no `rsp_valid` is issued.

Source files
------------

// File: rtl/apb_master_bridge_if.sv
// Request/response port and APB bus signals of apb_master_bridge.
// The master modport is the bridge's view; slave is the requester and APB slave side.
interface apb_master_bridge_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    // Core-side request/response
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [STRB_W-1:0] req_strb;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    // APB4 bus
    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [STRB_W-1:0] pstrb;
    logic              psel;
    logic              penable;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_strb,
        input  prdata, pready, pslverr,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output paddr, pwrite, pwdata, pstrb, psel, penable
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_strb,
        output prdata, pready, pslverr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  paddr, pwrite, pwdata, pstrb, psel, penable
    );
endinterface

// File: rtl/apb_master_bridge.sv
// APB4 requester: valid/ready request in, SETUP/ACCESS bus cycles out, one-cycle response strobe.
// Define APB_TIMEOUT_EN to abort ACCESS with an error after TIMEOUT_CYC wait edges.
module apb_master_bridge #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                pclk,
    input  logic                presetn,
    apb_master_bridge_if.master bus
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    if (DATA_W % 8 != 0) begin : g_chk_data_w
        $error("apb_master_bridge: DATA_W must be a multiple of 8");
    end
    if (TIMEOUT_CYC < 1) begin : g_chk_timeout
        $error("apb_master_bridge: TIMEOUT_CYC must be at least 1");
    end

    state_t            state_q,     state_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q,   rsp_err_d;
    logic [ADDR_W-1:0] paddr_q,     paddr_d;
    logic              pwrite_q,    pwrite_d;
    logic [DATA_W-1:0] pwdata_q,    pwdata_d;
    logic [STRB_W-1:0] pstrb_q,     pstrb_d;
    logic              psel_q,      psel_d;
    logic              penable_q,   penable_d;

    logic              timeout_hit;
    logic [DATA_W-1:0] wdata_acc;
    logic [STRB_W-1:0] strb_acc;

    // Reads put all-zero data and strobes on the bus, lane by lane.
    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
        assign wdata_acc[gi*8 +: 8] = bus.req_write ? bus.req_wdata[gi*8 +: 8] : 8'h00;
        assign strb_acc[gi]         = bus.req_write & bus.req_strb[gi];
    end

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // True on the wait edge that would bring the count to TIMEOUT_CYC.
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
`ifdef APB_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // req_ready rises on the first edge out of reset, so a request
                // is only taken once ready has been visible for a cycle.
                req_ready_d = 1'b1;
                if (bus.req_valid && req_ready_q) begin
                    paddr_d     = bus.req_addr;
                    pwrite_d    = bus.req_write;
                    pwdata_d    = wdata_acc;
                    pstrb_d     = strb_acc;
                    psel_d      = 1'b1;
                    req_ready_d = 1'b0;
                    state_d     = ST_SETUP;
                end
            end

            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
`ifdef APB_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end

            ST_ACCESS: begin
                if (bus.pready) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    pstrb_d     = '0;
                    pwrite_d    = 1'b0;
                    req_ready_d = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = bus.pslverr;
                    rsp_rdata_d = (!pwrite_q && !bus.pslverr) ? bus.prdata : '0;
                    state_d     = ST_IDLE;
                end else if (timeout_hit) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    pstrb_d     = '0;
                    pwrite_d    = 1'b0;
                    req_ready_d = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = ST_IDLE;
                end else begin
`ifdef APB_TIMEOUT_EN
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.pstrb     = pstrb_q;
    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed transfers driven from tasks,
// expected responses queued at request time and compared when rsp_valid pulses.
module tb_apb_master_bridge;
    localparam int ADDR_W      = 8;
    localparam int DATA_W      = 32;
    localparam int TIMEOUT_CYC = 4;

    logic pclk    = 1'b0;
    logic presetn = 1'b0;

    apb_master_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_master_bridge #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .pclk   (pclk),
        .presetn(presetn),
        .bus    (bus.master)
    );

    always #5 pclk = ~pclk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          rsp_seen = 0;
    logic [32:0] exp_q[$];   // {err, rdata}
    logic [32:0] mon_exp;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Response scoreboard, sampled on the falling edge.
    always @(negedge pclk) begin
        if (presetn && bus.rsp_valid) begin
            rsp_seen++;
            $display("rsp %0d: err=%0b rdata=0x%08h", rsp_seen, bus.rsp_err, bus.rsp_rdata);
            if (exp_q.size() == 0) begin
                check_val("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check_val("rsp_err", {63'd0, bus.rsp_err}, {63'd0, mon_exp[32]});
                check_val("rsp_rdata", {32'd0, bus.rsp_rdata}, {32'd0, mon_exp[31:0]});
            end
        end
    end

    task automatic do_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input int waits,
                           input logic [31:0] rdata, input logic err);
        logic [31:0] exp_wdata;
        logic [3:0]  exp_strb;
        exp_wdata = wr ? wdata : 32'h0;
        exp_strb  = wr ? strb : 4'h0;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_strb  = strb;
        exp_q.push_back({err, (!wr && !err) ? rdata : 32'h0});
        check_val("req_ready_idle", bus.req_ready, 1);
        tick();  // acceptance edge
        bus.req_valid = 1'b0;
        bus.req_addr  = ~addr;
        bus.req_wdata = ~wdata;
        bus.req_strb  = ~strb;
        check_val("setup_psel", bus.psel, 1);
        check_val("setup_penable", bus.penable, 0);
        check_val("setup_req_ready", bus.req_ready, 0);
        check_val("setup_paddr", bus.paddr, addr);
        check_val("setup_pwrite", bus.pwrite, wr);
        check_val("setup_pwdata", bus.pwdata, exp_wdata);
        check_val("setup_pstrb", bus.pstrb, exp_strb);
        bus.pready  = (waits == 0);
        bus.prdata  = (waits == 0) ? rdata : ~rdata;
        bus.pslverr = (waits == 0) ? err : ~err;
        tick();  // SETUP -> ACCESS
        check_val("access_penable", bus.penable, 1);
        check_val("access_psel", bus.psel, 1);
        check_val("access_paddr", bus.paddr, addr);
        for (int w = 0; w < waits; w++) begin
            tick();
            check_val("wait_no_rsp", bus.rsp_valid, 0);
            check_val("wait_penable", bus.penable, 1);
            check_val("wait_pwdata", bus.pwdata, exp_wdata);
            check_val("wait_pstrb", bus.pstrb, exp_strb);
            if (w == waits - 1) begin
                bus.pready  = 1'b1;
                bus.prdata  = rdata;
                bus.pslverr = err;
            end
        end
        tick();  // completion edge
        check_val("done_rsp_valid", bus.rsp_valid, 1);
        check_val("done_req_ready", bus.req_ready, 1);
        check_val("done_psel", bus.psel, 0);
        check_val("done_penable", bus.penable, 0);
        check_val("done_pstrb", bus.pstrb, 0);
        check_val("done_pwrite", bus.pwrite, 0);
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        bus.prdata  = 32'h0;
        tick();
        check_val("rsp_pulse_end", bus.rsp_valid, 0);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_strb  = '0;
        bus.prdata    = '0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;

        // Reset
        tick();
        tick();
        check_val("rst_req_ready", bus.req_ready, 0);
        check_val("rst_rsp_valid", bus.rsp_valid, 0);
        check_val("rst_rsp_rdata", bus.rsp_rdata, 0);
        check_val("rst_rsp_err", bus.rsp_err, 0);
        check_val("rst_paddr", bus.paddr, 0);
        check_val("rst_pwdata", bus.pwdata, 0);
        check_val("rst_psel", bus.psel, 0);
        check_val("rst_penable", bus.penable, 0);
        presetn = 1'b1;
        #1;
        check_val("ready_before_edge", bus.req_ready, 0);
        tick();
        check_val("ready_after_release", bus.req_ready, 1);

        // Zero-wait write, 2-wait read, slave error read, partial-strobe write with error
        do_xfer(1'b1, 8'h05, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0);
        do_xfer(1'b0, 8'h05, 32'h0, 4'hF, 2, 32'hA5A5A5A5, 1'b0);
        do_xfer(1'b0, 8'h10, 32'h0, 4'h0, 0, 32'h5555AAAA, 1'b1);
        do_xfer(1'b1, 8'h7F, 32'h01234567, 4'h3, 1, 32'hFFFFFFFF, 1'b1);

        // Back-to-back writes with req_valid held high
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 8'h01;
        bus.req_wdata = 32'h11111111;
        bus.req_strb  = 4'hF;
        bus.pready    = 1'b1;
        exp_q.push_back(33'h0);
        tick();
        check_val("b2b_setup1_psel", bus.psel, 1);
        check_val("b2b_setup1_paddr", bus.paddr, 8'h01);
        bus.req_addr  = 8'h02;
        bus.req_wdata = 32'h22222222;
        bus.req_strb  = 4'h3;
        exp_q.push_back(33'h0);
        tick();
        check_val("b2b_access1_penable", bus.penable, 1);
        check_val("b2b_access1_paddr", bus.paddr, 8'h01);
        tick();
        check_val("b2b_rsp1_valid", bus.rsp_valid, 1);
        check_val("b2b_rsp1_psel", bus.psel, 0);
        tick();
        check_val("b2b_setup2_psel", bus.psel, 1);
        check_val("b2b_setup2_penable", bus.penable, 0);
        check_val("b2b_setup2_paddr", bus.paddr, 8'h02);
        check_val("b2b_setup2_pwdata", bus.pwdata, 32'h22222222);
        check_val("b2b_setup2_pstrb", bus.pstrb, 4'h3);
        bus.req_valid = 1'b0;
        tick();
        check_val("b2b_access2_penable", bus.penable, 1);
        tick();
        check_val("b2b_rsp2_valid", bus.rsp_valid, 1);
        bus.pready = 1'b0;
        tick();

`ifdef APB_TIMEOUT_EN
        // Timeout: pready stuck low
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 8'h20;
        exp_q.push_back({1'b1, 32'h0});
        bus.prdata    = 32'hCAFEF00D;
        tick();
        bus.req_valid = 1'b0;
        tick();
        check_val("to_penable", bus.penable, 1);
        for (int w = 0; w < TIMEOUT_CYC - 1; w++) begin
            tick();
            check_val("to_no_rsp_yet", bus.rsp_valid, 0);
        end
        tick();
        check_val("to_rsp_valid", bus.rsp_valid, 1);
        check_val("to_psel", bus.psel, 0);
        check_val("to_penable_drop", bus.penable, 0);
        check_val("to_req_ready", bus.req_ready, 1);
        bus.prdata = 32'h0;
        tick();
`else
        // Reset in the middle of ACCESS
        begin
            int rsp_before;
            bus.req_valid = 1'b1;
            bus.req_write = 1'b0;
            bus.req_addr  = 8'h30;
            tick();
            bus.req_valid = 1'b0;
            tick();
            tick();
            check_val("mrst_penable_before", bus.penable, 1);
            rsp_before = rsp_seen;
            #2;
            presetn = 1'b0;
            #1;
            check_val("mrst_psel", bus.psel, 0);
            check_val("mrst_penable", bus.penable, 0);
            check_val("mrst_paddr", bus.paddr, 0);
            bus.pready = 1'b1;
            tick();
            check_val("mrst_no_rsp_valid", bus.rsp_valid, 0);
            tick();
            check_val("mrst_no_rsp_count", rsp_seen, rsp_before);
            bus.pready = 1'b0;
            presetn    = 1'b1;
            tick();
            check_val("mrst_ready_after", bus.req_ready, 1);
        end
`endif

        // Recovery transfer
        do_xfer(1'b0, 8'hC3, 32'h0, 4'hF, 1, 32'h3C3C3C3C, 1'b0);

        check_val("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end
endmodule
